// File: rtl/lap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lap_pkg
// Brief    : Shared widths, FSM state type and helpers for the Laplace sequencer.
// Revision : 1.0
// ============================================================================
package lap_pkg;

    localparam int PIX_W            = 8;
    localparam int RES_W            = 11;
    localparam int CENTER_SHIFT_DEF = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADD_N = 3'd1,
        ADD_S = 3'd2,
        ADD_E = 3'd3,
        ADD_W = 3'd4,
        SUB_C = 3'd5,
        OUT   = 3'd6
    } lap_state_t;

    // Magnitude of a two's-complement result, clipped to a pixel value.
    function automatic logic [PIX_W-1:0] abs_sat(input logic [RES_W-1:0] v);
        logic [RES_W-1:0] mag;
        mag = v[RES_W-1] ? (~v + 1'b1) : v;
        return (mag > RES_W'(255)) ? 8'hFF : mag[PIX_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lap4_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lap4_add_sequencer
// Brief    : Sequences N,S,E,W,-C through an external 8-bit adder to form the
//            4-neighbour Laplacian. Optional macro LAP_ABS_SAT_EN adds pix_out.
// Revision : 1.0
// ============================================================================
module lap4_add_sequencer
    import lap_pkg::*;
#(
    parameter int CENTER_SHIFT = CENTER_SHIFT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  pix_c,
    input  logic [PIX_W-1:0]  pix_n,
    input  logic [PIX_W-1:0]  pix_s,
    input  logic [PIX_W-1:0]  pix_e,
    input  logic [PIX_W-1:0]  pix_w,
    output logic [PIX_W-1:0]  add_a,
    output logic [PIX_W-1:0]  add_b,
    output logic              add_cin,
    input  logic [PIX_W-1:0]  add_s,
    input  logic              add_cout,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef LAP_ABS_SAT_EN
    output logic [PIX_W-1:0]  pix_out,
`endif
    output logic [RES_W-1:0]  lap_res
);

    localparam int c_k_shift = 2 - CENTER_SHIFT;

    lap_state_t       r_state;
    lap_state_t       w_next;
    logic [PIX_W-1:0] r_c, r_n, r_s, r_e, r_w;
    logic [PIX_W-1:0] r_acc_lo;
    logic [2:0]       r_acc_hi;
    logic [RES_W-1:0] r_lap_res;
    logic [9:0]       w_c4;
    logic [RES_W-1:0] w_k;
    logic [2:0]       w_hi_inc;
    logic [2:0]       w_acc_hi_nxt;
    logic             w_compute;
`ifdef LAP_ABS_SAT_EN
    logic [PIX_W-1:0] r_pix_out;
`endif

    // Centre weight: C * 2^CENTER_SHIFT, at most 1020, so bit 10 is always 0.
    assign w_c4 = {r_c, 2'b00};
    assign w_k  = {1'b0, (w_c4 >> c_k_shift)};

    always_comb begin
        w_next    = r_state;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        w_hi_inc  = 3'd0;
        w_compute = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) w_next = ADD_N;
            end
            ADD_N: begin
                add_a = r_acc_lo; add_b = r_n; w_compute = 1'b1; w_next = ADD_S;
            end
            ADD_S: begin
                add_a = r_acc_lo; add_b = r_s; w_compute = 1'b1; w_next = ADD_E;
            end
            ADD_E: begin
                add_a = r_acc_lo; add_b = r_e; w_compute = 1'b1; w_next = ADD_W;
            end
            ADD_W: begin
                add_a = r_acc_lo; add_b = r_w; w_compute = 1'b1; w_next = SUB_C;
            end
            SUB_C: begin
                // acc + ~K + 1: low byte through the adder, high bits added here
                add_a     = r_acc_lo;
                add_b     = ~w_k[7:0];
                add_cin   = 1'b1;
                w_hi_inc  = ~w_k[10:8];
                w_compute = 1'b1;
                w_next    = OUT;
            end
            OUT: begin
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_acc_hi_nxt = r_acc_hi + w_hi_inc + {2'b00, add_cout};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_c       <= '0;
            r_n       <= '0;
            r_s       <= '0;
            r_e       <= '0;
            r_w       <= '0;
            r_acc_lo  <= '0;
            r_acc_hi  <= '0;
            r_lap_res <= '0;
`ifdef LAP_ABS_SAT_EN
            r_pix_out <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && in_valid) begin
                r_c      <= pix_c;
                r_n      <= pix_n;
                r_s      <= pix_s;
                r_e      <= pix_e;
                r_w      <= pix_w;
                r_acc_lo <= '0;
                r_acc_hi <= '0;
            end else if (w_compute) begin
                r_acc_lo <= add_s;
                r_acc_hi <= w_acc_hi_nxt;
            end
            if (r_state == SUB_C) begin
                r_lap_res <= {w_acc_hi_nxt, add_s};
`ifdef LAP_ABS_SAT_EN
                r_pix_out <= abs_sat({w_acc_hi_nxt, add_s});
`endif
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == OUT);
    assign lap_res   = r_lap_res;
`ifdef LAP_ABS_SAT_EN
    assign pix_out   = r_pix_out;
`endif

endmodule
`default_nettype wire
